// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Responder side of the data-memory port. It accepts a read and/or
//   byte-enabled write request, holds a 2**ADDR_W x 32 SRAM, inserts
//   WAIT_STATES cycles of latency and returns the read word.
//
//   The memory access is performed on the last cycle of latency, so busy
//   covers exactly WAIT_STATES cycles after acceptance. With WAIT_STATES == 0
//   the access happens on the accept edge itself and busy never rises.
//   A read and a write in the same request read the old word and then commit
//   the new bytes.
//
//   Optional build macro: DMEM_LOAD_DECODE_EN
//     defined   : the returned word is narrowed to byte/half/word and
//                 sign- or zero-extended using the latched width, offset and
//                 zero_ext fields.
//     undefined : the raw 32-bit word is returned; width/offset/zero_ext
//                 inputs are ignored.
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int ADDR_W      = 11,
   parameter int WAIT_STATES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_read,
   input  logic [3:0]        req_writeb,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [1:0]        req_width,
   input  logic              req_zero_ext,
   input  logic [1:0]        req_word_addr,
   output logic              busy,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata
);

   // Load width encoding shared with the stage's store encoder.
   localparam logic [1:0] ENCDEC_BYTE = 2'd0;
   localparam logic [1:0] ENCDEC_HALF = 2'd1;
   localparam logic [1:0] ENCDEC_WORD = 2'd2;

   localparam int         DEPTH   = 1 << ADDR_W;
   // Counter preload: the WAIT state is visited WAIT_STATES times.
   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_ACCESS = 2'd2
   } state_t;

   // FSM and counter
   state_t            state_q;
   logic [3:0]        cnt_q;

   // Latched request
   logic              rd_q;
   logic [3:0]        wb_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;

   // Registered outputs
   logic              busy_q;
   logic              rsp_valid_q;
   logic [31:0]       rdata_q;

   // Storage (not reset)
   logic [31:0]       mem_q [DEPTH];

   // Access port selection
   logic              new_req_s;
   logic              accept_s;
   logic              acc_en_s;
   logic              acc_rd_s;
   logic [3:0]        acc_wb_s;
   logic [ADDR_W-1:0] acc_addr_s;
   logic [31:0]       acc_wdata_s;
   logic              use_live_s;
   logic [31:0]       mem_rd_s;
   logic [31:0]       rdata_next_s;

   assign new_req_s = req_read | (|req_writeb);
   assign accept_s  = (state_q == ST_IDLE) && new_req_s;
   assign mem_rd_s  = mem_q[acc_addr_s];

   // Select which request (live on the accept edge, or latched) drives the SRAM this cycle.
   always_comb begin
      acc_en_s    = 1'b0;
      acc_rd_s    = 1'b0;
      acc_wb_s    = 4'h0;
      use_live_s  = 1'b0;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
      if (rst) begin
         acc_en_s = 1'b0;
      end else if ((WAIT_STATES == 0) && accept_s) begin
         acc_en_s    = 1'b1;
         use_live_s  = 1'b1;
         acc_rd_s    = req_read;
         acc_wb_s    = req_writeb;
         acc_addr_s  = req_addr;
         acc_wdata_s = req_wdata;
      end else if (((state_q == ST_WAIT) && (cnt_q == 4'd0)) || (state_q == ST_ACCESS)) begin
         acc_en_s = 1'b1;
         acc_rd_s = rd_q;
         acc_wb_s = wb_q;
      end else begin
         acc_en_s = 1'b0;
      end
   end

`ifdef DMEM_LOAD_DECODE_EN
   logic [1:0] width_q;
   logic       zext_q;
   logic [1:0] off_q;
   logic [1:0] acc_width_s;
   logic       acc_zext_s;
   logic [1:0] acc_off_s;

   // Narrow a raw word to the requested load size and extend it to 32 bits.
   function automatic logic [31:0] load_decode(input logic [31:0] word,
                                               input logic [1:0]  width,
                                               input logic        zext,
                                               input logic [1:0]  off);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = 8'(word >> {off, 3'b000});
      h = 16'(word >> {off[1], 4'b0000});
      case (width)
         ENCDEC_BYTE: r = zext ? {24'd0, b} : {{24{b[7]}}, b};
         ENCDEC_HALF: r = zext ? {16'd0, h} : {{16{h[15]}}, h};
         ENCDEC_WORD: r = word;
         default:     r = word;
      endcase
      return r;
   endfunction

   assign acc_width_s  = use_live_s ? req_width     : width_q;
   assign acc_zext_s   = use_live_s ? req_zero_ext  : zext_q;
   assign acc_off_s    = use_live_s ? req_word_addr : off_q;
   assign rdata_next_s = load_decode(mem_rd_s, acc_width_s, acc_zext_s, acc_off_s);

   // Latch the load-decode attributes of an accepted request.
   always_ff @(posedge clk) begin
      if (rst) begin
         width_q <= 2'd0;
         zext_q  <= 1'b0;
         off_q   <= 2'd0;
      end else if (accept_s) begin
         width_q <= req_width;
         zext_q  <= req_zero_ext;
         off_q   <= req_word_addr;
      end
   end
`else
   logic unused_s;
   assign unused_s     = ^{req_width, req_zero_ext, req_word_addr, use_live_s, ENCDEC_BYTE,
                           ENCDEC_HALF, ENCDEC_WORD};
   assign rdata_next_s = mem_rd_s;
`endif

   // Commit byte-enabled writes; the read of the same word sees the old value.
   always_ff @(posedge clk) begin
      if (acc_en_s) begin
         for (int b = 0; b < 4; b++) begin
            if (acc_wb_s[b]) begin
               mem_q[acc_addr_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
            end
         end
      end
   end

   // Request FSM: accept, count wait states, and register busy/response outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         rd_q        <= 1'b0;
         wb_q        <= 4'h0;
         addr_q      <= '0;
         wdata_q     <= 32'd0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rdata_q     <= 32'd0;
      end else begin
         rsp_valid_q <= acc_en_s & acc_rd_s;
         if (acc_en_s && acc_rd_s) begin
            rdata_q <= rdata_next_s;
         end
         case (state_q)
            ST_IDLE: begin
               if (new_req_s) begin
                  rd_q    <= req_read;
                  wb_q    <= req_writeb;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  if (WAIT_STATES == 0) begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q <= ST_WAIT;
                     cnt_q   <= WS_LOAD;
                     busy_q  <= 1'b1;
                  end
               end
            end
            ST_WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q   <= cnt_q - 4'd1;
                  busy_q  <= 1'b1;
               end
            end
            ST_ACCESS: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= 4'd0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Two responders (WAIT_STATES 0 and 3) driven side by side; a word-array
//   reference model predicts read data, latency and busy duration.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
   localparam int AW = 11;
   localparam logic [1:0] W_BYTE = 2'd0;
   localparam logic [1:0] W_HALF = 2'd1;
   localparam logic [1:0] W_WORD = 2'd2;
`ifdef DMEM_LOAD_DECODE_EN
   localparam bit DECODE = 1'b1;
`else
   localparam bit DECODE = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                  rst;
   logic [1:0]            req_read;
   logic [1:0][3:0]       req_writeb;
   logic [1:0][AW-1:0]    req_addr;
   logic [1:0][31:0]      req_wdata;
   logic [1:0][1:0]       req_width;
   logic [1:0]            req_zero_ext;
   logic [1:0][1:0]       req_word_addr;
   logic [1:0]            busy;
   logic [1:0]            rsp_valid;
   logic [1:0][31:0]      rsp_rdata;

   dmem_responder #(.ADDR_W(AW), .WAIT_STATES(0)) u_ws0 (
      .clk(clk), .rst(rst), .req_read(req_read[0]), .req_writeb(req_writeb[0]),
      .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_width(req_width[0]),
      .req_zero_ext(req_zero_ext[0]), .req_word_addr(req_word_addr[0]),
      .busy(busy[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]));

   dmem_responder #(.ADDR_W(AW), .WAIT_STATES(3)) u_ws3 (
      .clk(clk), .rst(rst), .req_read(req_read[1]), .req_writeb(req_writeb[1]),
      .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_width(req_width[1]),
      .req_zero_ext(req_zero_ext[1]), .req_word_addr(req_word_addr[1]),
      .busy(busy[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]));

   int n_pass   = 0;
   int n_checks = 0;
   logic [31:0] mdl [2][2048];

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   // Reference load: pick the byte/half by arithmetic and extend numerically.
   function automatic logic [31:0] mdl_load(input logic [31:0] w, input logic [1:0] wid,
                                            input logic zx, input logic [1:0] off);
      int v;
      if (DECODE && wid == W_BYTE) begin
         v = int'((w >> (8 * off)) & 32'hFF);
         if (!zx && v >= 128) v = v - 256;
         return 32'(v);
      end
      if (DECODE && wid == W_HALF) begin
         v = int'((w >> (16 * off[1])) & 32'hFFFF);
         if (!zx && v >= 32768) v = v - 65536;
         return 32'(v);
      end
      return w;
   endfunction

   task automatic mdl_write(input int d, input logic [AW-1:0] a, input logic [3:0] wb,
                            input logic [31:0] wd);
      for (int i = 0; i < 4; i++) begin
         if (wb[i]) mdl[d][a][8*i +: 8] = wd[8*i +: 8];
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [AW-1:0] pick_addr;
      int r;
      r = $urandom_range(0, 16);
      return (r == 16) ? 11'h7FF : 11'(r);
   endfunction

   // Present one request for one cycle once idle, then observe the response window.
   task automatic do_req(input int d, input logic rd, input logic [3:0] wb,
                         input logic [AW-1:0] a, input logic [31:0] wd,
                         input logic [1:0] wid, input logic zx, input logic [1:0] off,
                         output int lat, output int nvalid, output int nbusy,
                         output logic [31:0] data);
      int n;
      n = 0;
      while (busy[d] !== 1'b0 && n < 40) begin
         tick;
         n++;
      end
      if (n >= 40) begin
         n_checks++;
         $display("FAIL idle_timeout: dut %0d busy stuck at %b", d, busy[d]);
      end
      req_read[d] = rd; req_writeb[d] = wb; req_addr[d] = a; req_wdata[d] = wd;
      req_width[d] = wid; req_zero_ext[d] = zx; req_word_addr[d] = off;
      tick;
      req_read[d] = 1'b0; req_writeb[d] = 4'h0;
      lat = -1; nvalid = 0; nbusy = 0; data = 32'd0;
      for (int k = 0; k <= ws_of(d) + 1; k++) begin
         if (rsp_valid[d] === 1'b1) begin
            if (lat < 0) begin
               lat = k;
               data = rsp_rdata[d];
            end
            nvalid++;
         end
         if (busy[d] === 1'b1) nbusy++;
         if (k < ws_of(d) + 1) tick;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick;
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (busy[d] !== 1'b0) $display("FAIL reset_busy: dut %0d got %b want 0", d, busy[d]);
         else n_pass++;
         n_checks++;
         if (rsp_valid[d] !== 1'b0) $display("FAIL reset_valid: dut %0d got %b want 0", d, rsp_valid[d]);
         else n_pass++;
         n_checks++;
         if (rsp_rdata[d] !== 32'd0) $display("FAIL reset_rdata: dut %0d got %h want 0", d, rsp_rdata[d]);
         else n_pass++;
      end
   endtask

   task automatic test_init;
      int lat, nv, nb;
      logic [31:0] data, wd;
      logic [AW-1:0] a;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i <= 16; i++) begin
            a  = (i == 16) ? 11'h7FF : 11'(i);
            wd = $urandom;
            do_req(d, 1'b0, 4'hF, a, wd, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
            mdl_write(d, a, 4'hF, wd);
            n_checks++;
            if (nv !== 0 || nb !== ws_of(d))
               $display("FAIL init_write: dut %0d valid=%0d busy=%0d want 0/%0d", d, nv, nb, ws_of(d));
            else n_pass++;
         end
      end
   endtask

   task automatic test_ws0_basic;
      int lat, nv, nb;
      logic [31:0] data;
      do_req(0, 1'b0, 4'hF, 11'd5, 32'h8000_00F1, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
      mdl_write(0, 11'd5, 4'hF, 32'h8000_00F1);
      n_checks++;
      if (nb !== 0 || nv !== 0) $display("FAIL ws0_write: busy=%0d valid=%0d want 0/0", nb, nv);
      else n_pass++;
      do_req(0, 1'b1, 4'h0, 11'd5, 32'd0, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
      n_checks++;
      if (lat !== 0 || nv !== 1) $display("FAIL ws0_latency: lat=%0d valid=%0d want 0/1", lat, nv);
      else n_pass++;
      n_checks++;
      if (nb !== 0) $display("FAIL ws0_busy: got %0d busy cycles want 0", nb);
      else n_pass++;
      n_checks++;
      if (data !== 32'h8000_00F1) $display("FAIL ws0_rdata: got %h want 800000f1", data);
      else n_pass++;
   endtask

   task automatic test_byte_merge;
      int lat, nv, nb;
      logic [31:0] data;
      for (int d = 0; d < 2; d++) begin
         do_req(d, 1'b0, 4'hF, 11'd2, 32'hAABB_CCDD, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
         do_req(d, 1'b0, 4'b0100, 11'd2, 32'h0011_0000, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
         mdl_write(d, 11'd2, 4'hF, 32'hAA11_CCDD);
         do_req(d, 1'b1, 4'h0, 11'd2, 32'd0, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
         n_checks++;
         if (data !== 32'hAA11_CCDD || lat !== ws_of(d))
            $display("FAIL byte_merge: dut %0d got %h lat %0d want aa11ccdd lat %0d", d, data, lat, ws_of(d));
         else n_pass++;
      end
   endtask

   task automatic test_read_before_write;
      int lat, nv, nb;
      logic [31:0] data;
      for (int d = 0; d < 2; d++) begin
         do_req(d, 1'b0, 4'hF, 11'd7, 32'h1234_5678, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
         do_req(d, 1'b1, 4'hF, 11'd7, 32'hDEAD_BEEF, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
         mdl_write(d, 11'd7, 4'hF, 32'hDEAD_BEEF);
         n_checks++;
         if (data !== 32'h1234_5678 || nv !== 1)
            $display("FAIL rbw_old: dut %0d got %h valid %0d want 12345678 valid 1", d, data, nv);
         else n_pass++;
         do_req(d, 1'b1, 4'h0, 11'd7, 32'd0, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
         n_checks++;
         if (data !== 32'hDEAD_BEEF) $display("FAIL rbw_new: dut %0d got %h want deadbeef", d, data);
         else n_pass++;
      end
   endtask

   task automatic test_load_decode;
      int lat, nv, nb;
      logic [31:0] data, e0, e1, e2;
      e0 = DECODE ? 32'hFFFF_FF80 : 32'h80FF_7F01;
      e1 = DECODE ? 32'h0000_7F01 : 32'h80FF_7F01;
      e2 = DECODE ? 32'h0000_007F : 32'h80FF_7F01;
      do_req(1, 1'b0, 4'hF, 11'd9, 32'h80FF_7F01, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
      mdl_write(1, 11'd9, 4'hF, 32'h80FF_7F01);
      do_req(1, 1'b1, 4'h0, 11'd9, 32'd0, W_BYTE, 1'b0, 2'd3, lat, nv, nb, data);
      n_checks++;
      if (data !== e0) $display("FAIL dec_byte3_sx: got %h want %h", data, e0);
      else n_pass++;
      do_req(1, 1'b1, 4'h0, 11'd9, 32'd0, W_HALF, 1'b1, 2'd0, lat, nv, nb, data);
      n_checks++;
      if (data !== e1) $display("FAIL dec_half0_zx: got %h want %h", data, e1);
      else n_pass++;
      do_req(1, 1'b1, 4'h0, 11'd9, 32'd0, W_BYTE, 1'b0, 2'd1, lat, nv, nb, data);
      n_checks++;
      if (data !== e2) $display("FAIL dec_byte1_sx: got %h want %h", data, e2);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      int lat, nv, nb;
      logic [31:0] data;
      while (busy[1] !== 1'b0) tick;
      req_read[1] = 1'b1; req_writeb[1] = 4'h0; req_addr[1] = 11'd3;
      req_width[1] = W_WORD; req_zero_ext[1] = 1'b0; req_word_addr[1] = 2'd0;
      tick;                                  // accept edge of read A
      req_addr[1] = 11'd6;                   // read B held from the first busy cycle
      for (int k = 1; k <= 3; k++) begin
         n_checks++;
         if (busy[1] !== 1'b1 || rsp_valid[1] !== 1'b0)
            $display("FAIL b2b_busyA: cycle +%0d busy %b valid %b want 1/0", k, busy[1], rsp_valid[1]);
         else n_pass++;
         tick;
      end
      n_checks++;
      if (rsp_valid[1] !== 1'b1 || busy[1] !== 1'b0 || rsp_rdata[1] !== mdl[1][3])
         $display("FAIL b2b_rspA: valid %b busy %b data %h want 1/0/%h", rsp_valid[1], busy[1], rsp_rdata[1], mdl[1][3]);
      else n_pass++;
      tick;                                  // B accepted on the previous edge
      req_read[1] = 1'b0; req_writeb[1] = 4'hF; req_addr[1] = 11'd4; req_wdata[1] = ~mdl[1][4];
      for (int k = 1; k <= 3; k++) begin
         n_checks++;
         if (busy[1] !== 1'b1 || rsp_valid[1] !== 1'b0)
            $display("FAIL b2b_busyB: cycle +%0d busy %b valid %b want 1/0", k, busy[1], rsp_valid[1]);
         else n_pass++;
         tick;
      end
      req_writeb[1] = 4'h0;                  // write shown only while busy: must be ignored
      n_checks++;
      if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== mdl[1][6])
         $display("FAIL b2b_rspB: valid %b data %h want 1/%h", rsp_valid[1], rsp_rdata[1], mdl[1][6]);
      else n_pass++;
      do_req(1, 1'b1, 4'h0, 11'd4, 32'd0, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
      n_checks++;
      if (data !== mdl[1][4]) $display("FAIL busy_ignored: got %h want %h", data, mdl[1][4]);
      else n_pass++;
   endtask

   task automatic test_reset_mid;
      int lat, nv, nb, seen;
      logic [31:0] data;
      while (busy[1] !== 1'b0) tick;
      req_read[1] = 1'b0; req_writeb[1] = 4'hF; req_addr[1] = 11'd10; req_wdata[1] = ~mdl[1][10];
      tick;
      req_writeb[1] = 4'h0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      n_checks++;
      if (busy[1] !== 1'b0 || rsp_valid[1] !== 1'b0 || rsp_rdata[1] !== 32'd0)
         $display("FAIL rst_mid_state: busy %b valid %b data %h want 0/0/0", busy[1], rsp_valid[1], rsp_rdata[1]);
      else n_pass++;
      do_req(1, 1'b1, 4'h0, 11'd10, 32'd0, W_WORD, 1'b0, 2'd0, lat, nv, nb, data);
      n_checks++;
      if (data !== mdl[1][10]) $display("FAIL rst_mid_write: got %h want %h", data, mdl[1][10]);
      else n_pass++;
      while (busy[1] !== 1'b0) tick;
      req_read[1] = 1'b1; req_addr[1] = 11'd11;
      tick;
      req_read[1] = 1'b0;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         if (rsp_valid[1] === 1'b1) seen++;
         tick;
      end
      n_checks++;
      if (seen !== 0) $display("FAIL rst_mid_read: got %0d responses want 0", seen);
      else n_pass++;
   endtask

   task automatic test_random;
      int lat, nv, nb, e_lat, e_nb;
      logic [31:0] data, wd, e_data;
      logic [AW-1:0] a;
      logic rd, zx;
      logic [3:0] wb;
      logic [1:0] wid, off;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 80; i++) begin
            rd = 1'($urandom); wb = 4'($urandom); a = pick_addr(); wd = $urandom;
            wid = 2'($urandom_range(0, 2)); zx = 1'($urandom); off = 2'($urandom);
            e_data = mdl_load(mdl[d][a], wid, zx, off);
            e_lat  = rd ? ws_of(d) : -1;
            e_nb   = (rd || wb != 4'h0) ? ws_of(d) : 0;
            do_req(d, rd, wb, a, wd, wid, zx, off, lat, nv, nb, data);
            mdl_write(d, a, wb, wd);
            n_checks++;
            if (lat !== e_lat || nv !== (rd ? 1 : 0) || nb !== e_nb)
               $display("FAIL rand_timing: dut %0d op %0d lat %0d valid %0d busy %0d want %0d/%0d/%0d",
                        d, i, lat, nv, nb, e_lat, rd ? 1 : 0, e_nb);
            else n_pass++;
            if (rd) begin
               n_checks++;
               if (data !== e_data)
                  $display("FAIL rand_rdata: dut %0d op %0d addr %0d got %h want %h", d, i, a, data, e_data);
               else n_pass++;
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      req_read = '0; req_writeb = '0; req_addr = '0; req_wdata = '0;
      req_width = '0; req_zero_ext = '0; req_word_addr = '0;
      test_reset;
      test_init;
      test_ws0_basic;
      test_byte_merge;
      test_read_before_write;
      test_load_decode;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
